// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I pipeline front end.
//   XLEN          : datapath / PC width
//   NOP_INSTR     : canonical RV32I no-op (addi x0, x0, 0)
//   fetch_entry_t : one prefetched instruction together with its PC
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/rv_fetch_fifo.sv
// Prefetch FIFO for the fetch stage.
// Shift-register organisation: entry 0 is always the head, so the head seen by
// decode comes straight out of flops with no read mux in front of it.
// Ports:
//   CLK, RSTn : clock, asynchronous active-low reset
//   push      : write din at the tail this cycle
//   pop       : retire the head this cycle (ignored when empty)
//   flush     : discard all entries; wins over push and pop
//   din       : entry to write
//   head      : current head entry (registered)
//   count     : number of valid entries, 0..DEPTH
module rv_fetch_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic            do_pop;
  logic [AW-1:0]   wr_idx;

  assign do_pop = pop & (count != '0);

  // After a pop everything shifts down one slot, so the tail slot for a
  // simultaneous push is one lower. The caller never pushes into a full FIFO,
  // so the truncation to AW bits is always exact.
  assign wr_idx = AW'(count - CW'(do_pop));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      if (do_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          mem[i] <= mem[i+1];
        end
      end
      if (push) begin
        mem[wr_idx] <= din;
      end
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  assign head = mem[0];

endmodule

// File: rtl/rv_fetch_unit.sv
// Decoupled instruction-fetch stage for the pipelined RV32I core.
// Issues one word request per cycle to a latency-1 instruction memory, buffers
// the returned words in a prefetch FIFO and hands {pc, instr} to decode over a
// valid/ready handshake. A redirect flushes everything, including a response
// still in flight, and restarts fetch at the (word-aligned) target.
// Ports:
//   CLK, RSTn      : clock, asynchronous active-low reset
//   fetch_en       : allows new memory requests
//   imem_req       : request strobe (one word per cycle)
//   imem_addr      : word address of the request
//   imem_rdata     : instruction word, valid the cycle after imem_req
//   if_valid       : head of FIFO valid
//   if_instr       : head instruction
//   if_pc          : head PC
//   id_ready       : decode takes the head this cycle
//   redirect_valid : flush and restart at redirect_pc
//   redirect_pc    : redirect target
//   misalign_err   : one-cycle pulse when the redirect target was not word aligned
module rv_fetch_unit
  import rv_pkg::*;
#(
  parameter int               XLEN     = rv_pkg::XLEN,
  parameter int               IADDR_W  = 10,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               fetch_en,
  output logic               imem_req,
  output logic [IADDR_W-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               if_valid,
  output logic [31:0]        if_instr,
  output logic [XLEN-1:0]    if_pc,
  input  logic               id_ready,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               misalign_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pc_q;
  logic            inflight;
  logic [CW-1:0]   count;
  logic            pop;
  logic            push;
  logic [CW:0]     occupancy;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign if_valid = (count != '0);
  assign pop      = if_valid & id_ready;

  // Slots already claimed once this edge completes: stored entries plus the
  // response on its way, minus the head leaving now. Counting the pop lets
  // fetch restart in the same cycle decode unstalls a full FIFO.
  assign occupancy = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);

  // RSTn gates the strobe so nothing is requested while reset is held,
  // independent of what fetch_en is doing.
  assign imem_req  = RSTn & fetch_en & ~redirect_valid &
                     (occupancy < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc[IADDR_W+1:2];

  // A redirect in the response cycle kills the response.
  assign push = inflight & ~redirect_valid;

  assign push_entry = '{pc: pc_q, instr: imem_rdata};

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      fetch_pc     <= RESET_PC;
      pc_q         <= '0;
      inflight     <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect_valid & (|redirect_pc[1:0]);
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        inflight <= 1'b0;
      end else begin
        inflight <= imem_req;
        if (imem_req) begin
          pc_q     <= fetch_pc;
          fetch_pc <= fetch_pc + XLEN'(4);
        end
      end
    end
  end

  rv_fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_entry),
    .head  (head),
    .count (count)
  );

  assign if_pc    = head.pc;
  assign if_instr = head.instr;

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Bench for rv_fetch_unit. Memory model returns (word address + 100) one cycle
// after each request. Every item decode accepts is popped from a scoreboard
// queue filled by the stimulus; cycle-exact points are checked directly.
module tb_rv_fetch_unit;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        fetch_en;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_err;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_xfer  = 0;
  int   base;

  rv_fetch_unit dut (
    .CLK            (CLK),
    .RSTn           (RSTn),
    .fetch_en       (fetch_en),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign_err   (misalign_err)
  );

  always #5 CLK = ~CLK;

  // Garbage when no request was made, so a bogus capture shows up.
  always @(posedge CLK) begin
    imem_rdata <= imem_req ? (32'(imem_addr) + 32'd100) : 32'hDEADBEEF;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = {22'd0, pc[11:2]} + 32'd100;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " imem_req"},     32'(imem_req),     32'd0);
    check({tag, " imem_addr"},    32'(imem_addr),    32'd0);
    check({tag, " if_valid"},     32'(if_valid),     32'd0);
    check({tag, " if_instr"},     if_instr,          32'd0);
    check({tag, " if_pc"},        if_pc,             32'd0);
    check({tag, " misalign_err"}, 32'(misalign_err), 32'd0);
  endtask

  task automatic do_reset(input bit chk_now);
    RSTn           = 1'b0;
    fetch_en       = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    exp_q.delete();
    if (chk_now) begin
      #1;
      check_reset("async_rst");
    end
    repeat (2) @(posedge CLK);
    #1;
    check_reset("reset");
  endtask

  task automatic start_run(input logic fe, input logic ir);
    RSTn     = 1'b1;
    fetch_en = fe;
    id_ready = ir;
  endtask

  task automatic drain_check(input string name, input int b, input int nexp);
    int k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      tick();
      k++;
    end
    repeat (3) tick();
    check({name, " left_in_queue"}, 32'(exp_q.size()), 32'd0);
    check({name, " transfers"},     32'(n_xfer - b),   32'(nexp));
  endtask

  // Monitor: every accepted head is compared against the scoreboard.
  always @(negedge CLK) begin
    if (RSTn === 1'b1 && if_valid === 1'b1 && id_ready === 1'b1 && redirect_valid === 1'b0) begin
      n_xfer++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_extra: got pc %h instr %h, expected no transfer", if_pc, if_instr);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_pc",    if_pc,    mon_e.pc);
        check("sb_instr", if_instr, mon_e.instr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, %0d tests run", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    // Streaming from reset
    do_reset(1'b0);
    for (int k = 0; k < 40; k++) expect_pc(32'(4 * k));
    base = n_xfer;
    start_run(1'b1, 1'b1);
    @(negedge CLK);
    check("p1 c1 imem_req",  32'(imem_req),  32'd1);
    check("p1 c1 imem_addr", 32'(imem_addr), 32'd0);
    tick(); @(negedge CLK);
    check("p1 c2 if_valid", 32'(if_valid), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick(); @(negedge CLK);
      check("p1 stream if_valid", 32'(if_valid), 32'd1);
      check("p1 stream if_pc",    if_pc,         32'(4 * c));
      check("p1 stream if_instr", if_instr,      32'(100 + c));
    end
    repeat (6) tick();
    check("p1 throughput", 32'(n_xfer - base), 32'd8);

    // Stall with decode not ready: fill, hold, resume
    do_reset(1'b0);
    for (int k = 0; k < 5; k++) expect_pc(32'(4 * k));
    base = n_xfer;
    start_run(1'b1, 1'b0);
    tick(); tick();
    for (int c = 3; c <= 8; c++) begin
      @(negedge CLK);
      check("p2 hold if_valid", 32'(if_valid), 32'd1);
      check("p2 hold if_pc",    if_pc,         32'd0);
      check("p2 hold if_instr", if_instr,      32'd100);
      if (c >= 5) check("p2 full imem_req", 32'(imem_req), 32'd0);
      tick();
    end
    id_ready = 1'b1;
    @(negedge CLK);
    check("p2 resume imem_req",  32'(imem_req),  32'd1);
    check("p2 resume imem_addr", 32'(imem_addr), 32'd4);
    tick();
    fetch_en = 1'b0;
    drain_check("p2", base, 5);

    // Redirect with 3 entries buffered and one response in flight
    do_reset(1'b0);
    base = n_xfer;
    start_run(1'b1, 1'b0);
    repeat (4) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    expect_pc(32'h40); expect_pc(32'h44); expect_pc(32'h48);
    @(negedge CLK);
    check("p3 redir imem_req", 32'(imem_req), 32'd0);
    tick();
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    @(negedge CLK);
    check("p3 +1 imem_req",  32'(imem_req),  32'd1);
    check("p3 +1 imem_addr", 32'(imem_addr), 32'h10);
    tick(); @(negedge CLK);
    check("p3 +2 if_valid", 32'(if_valid), 32'd0);
    tick(); @(negedge CLK);
    check("p3 +3 if_valid", 32'(if_valid), 32'd1);
    check("p3 +3 if_pc",    if_pc,         32'h40);
    check("p3 +3 if_instr", if_instr,      32'd116);
    tick();
    fetch_en = 1'b0;
    drain_check("p3", base, 3);

    // Misaligned redirect target
    base = n_xfer;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    fetch_en       = 1'b1;
    expect_pc(32'h40); expect_pc(32'h44);
    @(negedge CLK);
    check("p4 c0 misalign_err", 32'(misalign_err), 32'd0);
    tick();
    redirect_valid = 1'b0;
    @(negedge CLK);
    check("p4 c1 misalign_err", 32'(misalign_err), 32'd1);
    check("p4 c1 imem_addr",    32'(imem_addr),    32'h10);
    tick(); @(negedge CLK);
    check("p4 c2 misalign_err", 32'(misalign_err), 32'd0);
    tick();
    fetch_en = 1'b0;
    @(negedge CLK);
    check("p4 c3 if_valid", 32'(if_valid), 32'd1);
    check("p4 c3 if_pc",    if_pc,         32'h40);
    drain_check("p4", base, 2);

    // Back-to-back redirects: the later one wins
    base = n_xfer;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    fetch_en       = 1'b1;
    expect_pc(32'hC0); expect_pc(32'hC4);
    tick();
    redirect_pc = 32'hC0;
    @(negedge CLK);
    check("p5 c1 imem_req", 32'(imem_req), 32'd0);
    tick();
    redirect_valid = 1'b0;
    @(negedge CLK);
    check("p5 c2 imem_req",  32'(imem_req),  32'd1);
    check("p5 c2 imem_addr", 32'(imem_addr), 32'h30);
    tick(); @(negedge CLK);
    check("p5 c3 if_valid", 32'(if_valid), 32'd0);
    tick();
    fetch_en = 1'b0;
    @(negedge CLK);
    check("p5 c4 if_valid", 32'(if_valid), 32'd1);
    check("p5 c4 if_pc",    if_pc,         32'hC0);
    drain_check("p5", base, 2);

    // PC wrap at the top of the address space
    base = n_xfer;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    fetch_en       = 1'b1;
    expect_pc(32'hFFFF_FFF8); expect_pc(32'hFFFF_FFFC); expect_pc(32'h0);
    tick();
    redirect_valid = 1'b0;
    @(negedge CLK);
    check("p6 c1 imem_addr", 32'(imem_addr), 32'h3FE);
    tick(); @(negedge CLK);
    check("p6 c2 imem_addr", 32'(imem_addr), 32'h3FF);
    tick(); @(negedge CLK);
    check("p6 c3 imem_req",  32'(imem_req),  32'd1);
    check("p6 c3 imem_addr", 32'(imem_addr), 32'h0);
    tick();
    fetch_en = 1'b0;
    drain_check("p6", base, 3);

    // Reset asserted mid-stream, between clock edges
    fetch_en = 1'b1;
    id_ready = 1'b0;
    repeat (3) tick();
    @(negedge CLK);
    check("p7 pre-reset if_valid", 32'(if_valid), 32'd1);
    #2;
    do_reset(1'b1);
    base = n_xfer;
    expect_pc(32'h0); expect_pc(32'h4);
    start_run(1'b1, 1'b1);
    tick(); tick();
    fetch_en = 1'b0;
    drain_check("p7", base, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_fetch_unit.md
Name: rv_fetch_unit

Overview:
- Decoupled instruction-fetch stage for the next-generation pipelined RV32I core. Replaces the free-running PC plus IF/ID register.
- Issues word requests to a fixed-latency-1 instruction memory and buffers responses in a parametrised prefetch FIFO.
- Presents {pc, instr} to decode with a valid/ready handshake, so decode can stall.
- Supports single-cycle flush/redirect from branch/jump resolution; in-flight responses are discarded.

Parameters:
XLEN, 32, datapath and PC width
IADDR_W, 10, instruction memory word-address width
DEPTH, 4, prefetch FIFO entries (power of two, >=2)
RESET_PC, 0, PC value loaded at reset (word aligned)

Ports:
CLK  input  1  clock
RSTn  input  1  asynchronous active-low reset
fetch_en  input  1  permits new memory requests
imem_req  output  1  request strobe, one word per cycle
imem_addr  output  IADDR_W  word address = pc[IADDR_W+1:2]
imem_rdata  input  32  instruction word, valid in the cycle after imem_req
if_valid  output  1  FIFO head valid
if_instr  output  32  head instruction
if_pc  output  XLEN  head PC
id_ready  input  1  decode accepts head this cycle
redirect_valid  input  1  flush and redirect request
redirect_pc  input  XLEN  redirect target
misalign_err  output  1  one-cycle pulse: redirect target had [1:0]!=0

Behaviour:
- Reset (async): fetch_pc=RESET_PC, FIFO count=0, inflight=0, imem_req=0, imem_addr=RESET_PC[IADDR_W+1:2], if_valid=0, if_instr=0, if_pc=0, misalign_err=0.
- pop = if_valid & id_ready. Head advances at the clock edge. While id_ready=0, if_instr and if_pc hold stable.
- Issue rule, combinational: imem_req = fetch_en & !redirect_valid & (count + inflight - pop < DEPTH).
  - Combinational path id_ready -> imem_req is permitted.
  - With imem_req=1, at the edge: inflight<=1, pc_q<=fetch_pc, fetch_pc<=fetch_pc+4 (wraps mod 2^XLEN). Otherwise inflight<=0.
- Response: when inflight=1 and no redirect, imem_rdata and pc_q are pushed at that edge. No overflow is possible by construction.
- Steady-state throughput is 1 instr/cycle for DEPTH>=2 with id_ready=1.
- Redirect has highest priority. At the edge with redirect_valid=1:
  - FIFO cleared (count=0).
  - inflight<=0; the response arriving next cycle is ignored.
  - fetch_pc<={redirect_pc[XLEN-1:2],2'b00}.
  - A simultaneous pop or push is discarded.
  - misalign_err<=|redirect_pc[1:0] for one cycle.
- Redirect latency:
  - Cycle 0: redirect_valid.
  - Cycle 1: imem_req with target.
  - Cycle 2: rdata.
  - Cycle 3: if_valid=1, if_pc=target.
- Back-to-back redirects: the last one wins; earlier targets are never presented.
- fetch_en=0: no new requests. An outstanding response is still captured. The FIFO drains normally.
- FIFO full with id_ready=0: imem_req=0. Fetch resumes the same cycle id_ready rises, via the pop term.
- if_valid=0 means empty; if_instr and if_pc are don't-care but must not be X after reset.
- Reset mid-operation clears all state immediately; a memory response in the following cycle is ignored.

Decomposition:
- Shared package rv_pkg:
  - XLEN
  - NOP_INSTR=32'h00000013
  - fetch_entry_t struct {pc[XLEN], instr[32]}
- Sub-module rv_fetch_fifo:
  - Parametrised DEPTH; entries are fetch_entry_t.
  - push, pop, flush inputs; count output.
  - Registered head output; flush has priority over push/pop.
- Issue/PC logic stays in rv_fetch_unit.

Test Plan:
- Reset release, fetch_en=1, id_ready=1, memory returns word at address 4*a = a+100:
  - Cycle 1: imem_req with addr 0.
  - From cycle 3: if_pc=0,4,8,... with if_instr=100,101,102 on consecutive cycles.
- id_ready=0 from cycle 3, DEPTH=4:
  - FIFO fills to 4, then imem_req=0; if_pc holds 0.
  - id_ready=1: pcs 0,4,8,12,16 emerge in order, no gaps, no duplicates.
- redirect_valid with redirect_pc=0x40 while FIFO holds 3 entries and one response is in flight:
  - Flushed entries and the in-flight response never appear.
  - Cycle +1: imem_addr=0x10.
  - Cycle +3: if_valid with if_pc=0x40.
- redirect_pc=0x42: misalign_err=1 for exactly one cycle; next if_pc=0x40.
- Redirect to 0x80 then 0xC0 on consecutive cycles: first presented if_pc=0xC0; 0x80 never appears.
- fetch_pc=0xFFFFFFFC (XLEN=32): next fetched pc=0x00000000. Also assert RSTn low mid-stream: all outputs return to reset values asynchronously.
